// File: rtl/secuenciador_fases.sv
`default_nettype none
// ============================================================================
//  Module      : secuenciador_fases
//  Description : Moore control FSM that sequences NUM_FASES phases, repeated
//                NUM_CICLOS times. Each phase lasts one full interval of an
//                external timer. The block enables that timer
//                (AbilitarCuenta) and consumes its end-of-count flag
//                (FinalCuenta).
//
//  Ports
//    Clk            in   system clock, rising edge
//    Reset          in   synchronous, active-high reset
//    Inicio         in   start request, level-sampled, honoured only in REPOSO
//    Detener        in   abort request; returns to REPOSO from any busy state
//    FinalCuenta    in   end-of-interval flag from the timer
//    AbilitarCuenta out  timer enable; low clears the timer count
//    Fase           out  current phase index   [ANCHO_FASE-1:0]
//    CicloActual    out  current cycle index   [ANCHO_CICLO-1:0]
//    Ocupado        out  run in progress
//    CambioFase     out  one-cycle pulse at each phase end
//    Terminado      out  one-cycle pulse on normal run completion
//
//  Build option
//    SECUENCIA_CONTINUA_EN : when defined, the last phase of the last cycle
//                            wraps to phase 0 / cycle 0 instead of finishing.
//                            FIN is never reached; only Detener or Reset end
//                            the run.
//
//  Revision    : 1.0  initial release
// ============================================================================
module secuenciador_fases #(
   parameter int NUM_FASES   = 4,
   parameter int ANCHO_FASE  = 2,
   parameter int NUM_CICLOS  = 3,
   parameter int ANCHO_CICLO = 4
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   Inicio,
   input  logic                   Detener,
   input  logic                   FinalCuenta,
   output logic                   AbilitarCuenta,
   output logic [ANCHO_FASE-1:0]  Fase,
   output logic [ANCHO_CICLO-1:0] CicloActual,
   output logic                   Ocupado,
   output logic                   CambioFase,
   output logic                   Terminado
);

   // State encoding
   localparam logic [2:0] REPOSO   = 3'd0;
   localparam logic [2:0] LIMPIAR  = 3'd1;
   localparam logic [2:0] CONTANDO = 3'd2;
   localparam logic [2:0] AVANZAR  = 3'd3;
   localparam logic [2:0] FIN      = 3'd4;

   // Last legal index values, sized to the output widths
   localparam logic [ANCHO_FASE-1:0]  ULTIMA_FASE  = ANCHO_FASE'(NUM_FASES - 1);
   localparam logic [ANCHO_CICLO-1:0] ULTIMO_CICLO = ANCHO_CICLO'(NUM_CICLOS - 1);

   logic [2:0]             estado;
   logic [2:0]             estado_sig;
   logic [ANCHO_FASE-1:0]  fase_sig;
   logic [ANCHO_CICLO-1:0] ciclo_sig;

   // ------------------------------------------------------------------------
   // Next-state and next-index logic.
   // Detener is checked before FinalCuenta and before any index update so an
   // abort always wins and leaves the indices at their last values.
   // ------------------------------------------------------------------------
   always_comb begin
      estado_sig = estado;
      fase_sig   = Fase;
      ciclo_sig  = CicloActual;
      case (estado)
         REPOSO: begin
            if (Inicio && !Detener) begin
               estado_sig = LIMPIAR;
               fase_sig   = '0;
               ciclo_sig  = '0;
            end
         end
         LIMPIAR: begin
            if (Detener) estado_sig = REPOSO;
            else         estado_sig = CONTANDO;
         end
         CONTANDO: begin
            if (Detener)          estado_sig = REPOSO;
            else if (FinalCuenta) estado_sig = AVANZAR;
         end
         AVANZAR: begin
            if (Detener) begin
               estado_sig = REPOSO;
            end else if (Fase < ULTIMA_FASE) begin
               estado_sig = CONTANDO;
               fase_sig   = Fase + 1'b1;
            end else if (CicloActual < ULTIMO_CICLO) begin
               estado_sig = CONTANDO;
               fase_sig   = '0;
               ciclo_sig  = CicloActual + 1'b1;
            end else begin
`ifdef SECUENCIA_CONTINUA_EN
               estado_sig = CONTANDO;
               fase_sig   = '0;
               ciclo_sig  = '0;
`else
               // Indices keep their final values through FIN and REPOSO
               estado_sig = FIN;
`endif
            end
         end
         FIN: begin
            estado_sig = REPOSO;
         end
         default: begin
            estado_sig = REPOSO;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State, index and output registers.
   // Flags are decoded from the next state and registered, so each output is
   // a flop whose value corresponds exactly to the current state (Moore) with
   // no combinational input-to-output path.
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (Reset) begin
         estado         <= REPOSO;
         Fase           <= '0;
         CicloActual    <= '0;
         AbilitarCuenta <= 1'b0;
         Ocupado        <= 1'b0;
         CambioFase     <= 1'b0;
         Terminado      <= 1'b0;
      end else begin
         estado         <= estado_sig;
         Fase           <= fase_sig;
         CicloActual    <= ciclo_sig;
         AbilitarCuenta <= (estado_sig == CONTANDO);
         Ocupado        <= (estado_sig == LIMPIAR) ||
                           (estado_sig == CONTANDO) ||
                           (estado_sig == AVANZAR);
         CambioFase     <= (estado_sig == AVANZAR);
         Terminado      <= (estado_sig == FIN);
      end
   end

endmodule
`default_nettype wire
